// File: rtl/sipo_pkg.sv
// sipo_pkg: shared FSM states, default width and counter sizing for the sipo deserializer
package sipo_pkg;
  typedef enum logic {S_IDLE, S_SHIFT} state_e;
  localparam int DW_DEF = 4;
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 2);
  endfunction
endpackage

// File: rtl/sipo_bit_cnt.sv
// sipo_bit_cnt: frame bit counter; sync reloads to 1, done strobes on the bit that completes the frame
module sipo_bit_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          sync,
  input  logic [CW-1:0] flen,
  output logic [CW-1:0] cnt,
  output logic          done
);
  logic [CW-1:0] cnt_q, cnt_d, nxt;
  always_comb begin
    nxt = sync ? CW'(1) : cnt_q + CW'(1);
    done = inc && nxt == flen;
    cnt_d = !inc ? cnt_q : done ? '0 : nxt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with sync framing, valid/ready output and sticky overrun.
// Define SIPO_PARITY_EN to append a trailing even-parity bit to every frame.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          i_sdata,
  input  logic          i_svalid,
  input  logic          i_sync,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_overrun,
  output logic          o_perr
);
  localparam int CW = cnt_w(DW);
`ifdef SIPO_PARITY_EN
  localparam int FLEN = DW + 1;
`else
  localparam int FLEN = DW;
`endif
  state_e        state_q, state_d;
  logic [DW-1:0] sr_q, sr_d, sr_base, data_q, data_d, word;
  logic          valid_q, valid_d, ovr_q, ovr_d, perr_q, perr_d;
  logic [CW-1:0] cnt;
  logic          acc, done, bad, load, drop;
  assign acc = enb && i_svalid;
  sipo_bit_cnt #(.CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (acc),
    .sync(i_sync),
    .flen(CW'(FLEN)),
    .cnt (cnt),
    .done(done)
  );
  // a new frame (idle start or sync) shifts into a cleared register so partial words never leak
  always_comb begin
    sr_base = (i_sync || state_q == S_IDLE) ? '0 : sr_q;
    sr_d = sr_q;
    if (acc && (i_sync || cnt < CW'(DW)))
      sr_d = MSB_FIRST ? {sr_base[DW-2:0], i_sdata} : {i_sdata, sr_base[DW-1:1]};
`ifdef SIPO_PARITY_EN
    word = sr_q;
    bad = done && ^{sr_q, i_sdata};
`else
    word = sr_d;
    bad = 1'b0;
`endif
    state_d = acc ? (done ? S_IDLE : S_SHIFT) : state_q;
    load = done && !bad && (!valid_q || i_ready);
    drop = done && !bad && valid_q && !i_ready;
    valid_d = load || (valid_q && !i_ready);
    data_d = load ? word : data_q;
    ovr_d = ovr_q || drop;
    perr_d = bad;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;
  assign o_perr    = perr_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed checks of framing, stall/overrun, sync, enable gating, reset and parity
module tb_sipo_deser;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b1;
  logic       i_sdata = 1'b0;
  logic       i_svalid = 1'b0;
  logic       i_sync = 1'b0;
  logic       i_ready = 1'b1;
  logic [3:0] d0, d1;
  logic       v0, v1, o0, o1, p0, p1;
  int         n_chk = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  sipo_deser #(.DW(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .enb(enb), .i_sdata(i_sdata), .i_svalid(i_svalid), .i_sync(i_sync),
    .o_data(d0), .o_valid(v0), .i_ready(i_ready), .o_overrun(o0), .o_perr(p0)
  );
  sipo_deser #(.DW(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .enb(enb), .i_sdata(i_sdata), .i_svalid(i_svalid), .i_sync(i_sync),
    .o_data(d1), .o_valid(v1), .i_ready(i_ready), .o_overrun(o1), .o_perr(p1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bit_in(input logic b, input logic s);
    i_sdata = b;
    i_svalid = 1'b1;
    i_sync = s;
    @(posedge clk);
    #1;
    i_svalid = 1'b0;
    i_sync = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // sends w[3] first; appends even parity (xor with par_flip to corrupt it) in the parity build
  task automatic send_word(input logic [3:0] w, input logic s, input logic par_flip);
    for (int i = 3; i >= 0; i--) bit_in(w[i], s && i == 3);
`ifdef SIPO_PARITY_EN
    bit_in(^w ^ par_flip, 1'b0);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
  endtask
  initial begin
    #2;
    chk("rst_data", d0, 4'h0);
    chk("rst_valid", v0, 1'b0);
    chk("rst_ovr", o0, 1'b0);
    chk("rst_perr", p0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    // basic frame 1,0,1,1
    bit_in(1'b1, 1'b0);
    chk("basic_nv1", v0, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    chk("basic_nv3", v0, 1'b0);
    bit_in(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    chk("basic_nv4", v0, 1'b0);
    bit_in(1'b1, 1'b0);
`endif
    chk("basic_valid", v0, 1'b1);
    chk("basic_data", d0, 4'hB);
    chk("basic_lsb", d1, 4'hD);
    chk("basic_perr", p0, 1'b0);
    idle(1);
    chk("basic_drop", v0, 1'b0);
    // back-to-back frames, consume and complete on the same edge
    send_word(4'h9, 1'b0, 1'b0);
    chk("b2b_d1", d0, 4'h9);
    send_word(4'h6, 1'b0, 1'b0);
    chk("b2b_v2", v0, 1'b1);
    chk("b2b_d2", d0, 4'h6);
    chk("b2b_ovr", o0, 1'b0);
    idle(1);
    // stall and overrun
    i_ready = 1'b0;
    send_word(4'hB, 1'b0, 1'b0);
    chk("stall_v", v0, 1'b1);
    chk("stall_ovr0", o0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    chk("stall_d", d0, 4'hB);
    chk("stall_v2", v0, 1'b1);
    chk("stall_ovr1", o0, 1'b1);
    i_ready = 1'b1;
    idle(1);
    chk("stall_xfer", v0, 1'b0);
    chk("stall_sticky", o0, 1'b1);
    // sync resynchronisation discards the partial 1,0
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    chk("sync_nv", v0, 1'b0);
    send_word(4'h6, 1'b1, 1'b0);
    chk("sync_v", v0, 1'b1);
    chk("sync_d", d0, 4'h6);
    idle(1);
    chk("sync_single", v0, 1'b0);
    // enable gating
    enb = 1'b0;
    for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b0);
    chk("enb_nv", v0, 1'b0);
    enb = 1'b1;
    send_word(4'h3, 1'b0, 1'b0);
    chk("enb_v", v0, 1'b1);
    chk("enb_d", d0, 4'h3);
    idle(1);
    // reset mid-frame, asynchronous assertion
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst_data", d0, 4'h0);
    chk("mrst_valid", v0, 1'b0);
    chk("mrst_ovr", o0, 1'b0);
    chk("mrst_perr", p0, 1'b0);
    idle(1);
    rst = 1'b1;
    send_word(4'h5, 1'b0, 1'b0);
    chk("mrst_v", v0, 1'b1);
    chk("mrst_msb", d0, 4'h5);
    chk("mrst_lsb", d1, 4'hA);
    idle(1);
`ifdef SIPO_PARITY_EN
    send_word(4'hB, 1'b0, 1'b1);
    chk("par_perr", p0, 1'b1);
    chk("par_nv", v0, 1'b0);
    chk("par_keep", d0, 4'h5);
    idle(1);
    chk("par_pulse", p0, 1'b0);
    chk("par_novr", o0, 1'b0);
    send_word(4'hB, 1'b0, 1'b0);
    chk("par_ok_v", v0, 1'b1);
    chk("par_ok_d", d0, 4'hB);
    chk("par_ok_perr", p0, 1'b0);
`else
    chk("noparity_perr", p0, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
